ex_unit_pipe: RTL and testbench
===============================

Name: ex_unit_pipe

Overview:
- Parametrised, handshaked execute stage for the 6-bit-opcode integer core. Sits between decode/register-read and memory/writeback.
- Computes ALU results, load/store effective addresses and next-PC for branches and jumps.
- New in this generation: configurable datapath width, valid/ready flow control with backpressure, true two's-complement subtract, signed-overflow and illegal-opcode flags, and an iterative multi-cycle multiplier.

Parameters:
- WIDTH, 32, datapath width in bits for operands, results and PC.
- MUL_STEP, 1, multiplier bits retired per cycle. Must divide WIDTH evenly; MUL_ITERS = WIDTH/MUL_STEP.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  6  opcode (ex_pkg::op_e).
- rs  in  WIDTH  source operand 1.
- rt  in  WIDTH  source operand 2.
- imm  in  WIDTH  sign-extended immediate.
- pc4  in  WIDTH  PC+4 of this instruction.
- br_off  in  WIDTH  branch offset, already scaled.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  downstream accepts the result.
- rd  out  WIDTH  arithmetic/logic result.
- addr  out  WIDTH  LDW/STW effective address.
- pc_next  out  WIDTH  redirect target.
- br_taken  out  1  redirect pc_next is valid.
- ovf  out  1  signed overflow on ADD/ADDI/SUB/SUBI.
- illegal  out  1  opcode not in op_e.

Behaviour:
- Reset: state=IDLE; out_valid, rd, addr, pc_next, br_taken, ovf, illegal all 0; multiplier aborted. A reset mid-multiply discards the operation and produces no output.
- in_ready = (state==IDLE) && (!out_valid || out_ready). An operation is accepted on in_valid && in_ready.
- Output hold: while out_valid && !out_ready, every output stays stable. out_valid falls after the handshake unless a new result loads in the same cycle.
- Single-cycle ops (every op except MUL/MULI): outputs load on the accepting edge, so out_valid=1 the next cycle. Back-to-back throughput is 1 op/cycle when out_ready=1.
- Opcodes: all arithmetic is modulo 2^WIDTH.
  - 00 ADD: rd = rs+rt.
  - 01 ADDI: rd = rs+imm.
  - 02 SUB: rd = rs-rt.
  - 03 SUBI: rd = rs-imm.
  - 04 MUL: rd = low WIDTH bits of rs*rt.
  - 05 MULI: rd = low WIDTH bits of rs*imm.
  - 06 OR, 07 ORI, 08 AND, 09 ANDI, 0A XOR, 0B XORI: bitwise, with rt or imm as second operand.
  - 0C LDW and 0D STW: addr = rs+imm.
  - 0E BZ: taken iff rs==0.
  - 0F BEQ: taken iff rs==rt.
  - 10 JR: pc_next = rs, br_taken=1.
- Output fields not defined by the opcode are 0.
- Branches: if taken, pc_next = pc4+br_off and br_taken=1. If not taken, pc_next = pc4 and br_taken=0.
- ovf: set only for ADD/ADDI/SUB/SUBI, when the operand signs make the signed result wrap. For all other opcodes ovf=0; multiply overflow is not reported.
- Illegal opcode (>0x10): accepted as a single-cycle op; all results 0, illegal=1.
- Multiply FSM, states IDLE -> MUL -> DONE:
  - On acceptance, latch both operands, clear the accumulator and counter, go to MUL. in_ready=0 from the following cycle until return to IDLE.
  - MUL runs exactly MUL_ITERS cycles, each shift-adding MUL_STEP multiplier bits. The low WIDTH bits are sign-agnostic, so no sign correction is applied.
  - On the last iteration go to DONE. DONE loads rd and sets out_valid, then goes to IDLE.
  - If out_valid is still held by a stalled previous result, MUL does not start (enforced by in_ready). DONE therefore never overwrites an unaccepted result.
  - Latency accept -> out_valid = MUL_ITERS+1 cycles; 33 at defaults.
- Operand inputs are sampled only at acceptance. Later changes on those inputs have no effect.

Decomposition:
- Package ex_pkg holds:
  - op_e enum: the 17 opcodes above, 6-bit.
  - state_e: IDLE/MUL/DONE.
  - Function is_imm_op(op).
  - Constants OP_LAST=6'h10 and DEF_WIDTH=32.
- Sub-module ex_mul_iter (WIDTH, MUL_STEP) owns the operand latches, accumulator and iteration counter.
  - start/abort inputs; done pulse; product output.
  - abort is driven by rst.
- The top level owns the handshake, single-cycle datapath, FSM sequencing and output registers.

Test Plan:
- Reset then ADD rs=0x7FFFFFFF, rt=1, out_ready=1 -> next cycle out_valid=1, rd=0x80000000, ovf=1, br_taken=0.
- SUBI rs=5, imm=7 -> rd=0xFFFFFFFE, ovf=0. Follow with ANDI rs=0xF0F0, imm=0xFF on the next cycle -> rd=0xF0, 1 op/cycle sustained.
- MUL rs=0xFFFFFFFD (-3), rt=7 -> in_ready=0 for 33 cycles, then rd=0xFFFFFFEB. Repeat with MUL_STEP=4 -> latency 9.
- BEQ rs=rt=9, pc4=0x100, br_off=0x20 -> pc_next=0x120, br_taken=1. Then BZ rs=1 -> pc_next=0x104, br_taken=0. Then JR rs=0x400 -> pc_next=0x400, br_taken=1.
- Hold out_ready=0 for 4 cycles after an LDW rs=0x1000, imm=0x10 -> addr=0x1010 stable, in_ready=0. Release -> next op accepted the same cycle.
- Assert rst 10 cycles into a MUL -> out_valid stays 0, in_ready=1 after reset, and a following ADD 2+3 gives rd=5. Separately, op=0x2A -> illegal=1, rd=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared opcode, state and helper definitions for the integer execute stage.
package ex_pkg;

    localparam int         DEF_WIDTH = 32;
    localparam logic [5:0] OP_LAST   = 6'h10;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
        OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
        OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
        OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
        OP_JR   = 6'h10
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ops whose second operand is the immediate rather than rt.
    function automatic logic is_imm_op(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI,
            OP_LDW, OP_STW: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle;
// only the low WIDTH bits of the product are kept.
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int ITERS = WIDTH / MUL_STEP;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [WIDTH-1:0] partial;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, last;

    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
        last     = busy_q && (cnt_q == CNT_W'(ITERS - 1));
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = mcand;
            mplier_d = mplier;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << MUL_STEP;
            mplier_d = mplier_q >> MUL_STEP;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (abort) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign done    = last;
    assign product = acc_q;

endmodule

// File: rtl/ex_unit_pipe.sv
// Handshaked execute stage: single-cycle ALU/address/branch datapath plus
// an IDLE -> MUL -> DONE sequencer around the iterative multiplier.
module ex_unit_pipe
    import ex_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc4,
    input  logic [WIDTH-1:0] br_off,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] pc_next,
    output logic             br_taken,
    output logic             ovf,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d, br_taken_q, br_taken_d;
    logic             ovf_q, ovf_d, illegal_q, illegal_d;
    logic [WIDTH-1:0] rd_q, rd_d, addr_q, addr_d, pc_next_q, pc_next_d;

    logic [WIDTH-1:0] opnd2, sum, diff;
    logic [WIDTH-1:0] alu_rd, alu_addr, alu_pc, mul_product;
    logic             alu_br, alu_ovf, alu_ill, alu_mul;
    logic             accept, mul_start, mul_done;

    assign opnd2 = is_imm_op(op) ? imm : rt;
    assign sum   = rs + opnd2;
    assign diff  = rs - opnd2;

    always_comb begin
        alu_rd   = '0;
        alu_addr = '0;
        alu_pc   = '0;
        alu_br   = 1'b0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        alu_mul  = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                alu_rd  = sum;
                alu_ovf = (rs[WIDTH-1] == opnd2[WIDTH-1]) && (sum[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_SUB, OP_SUBI: begin
                alu_rd  = diff;
                alu_ovf = (rs[WIDTH-1] != opnd2[WIDTH-1]) && (diff[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_MUL, OP_MULI: alu_mul  = 1'b1;
            OP_OR,  OP_ORI:  alu_rd   = rs | opnd2;
            OP_AND, OP_ANDI: alu_rd   = rs & opnd2;
            OP_XOR, OP_XORI: alu_rd   = rs ^ opnd2;
            OP_LDW, OP_STW:  alu_addr = sum;
            OP_BZ, OP_BEQ: begin
                alu_br = (op == OP_BZ) ? (rs == '0) : (rs == rt);
                alu_pc = alu_br ? (pc4 + br_off) : pc4;
            end
            OP_JR: begin
                alu_pc = rs;
                alu_br = 1'b1;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // A new op is only taken when the output stage is free or draining now.
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        pc_next_d   = pc_next_q;
        br_taken_d  = br_taken_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        mul_start   = 1'b0;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && alu_mul) begin
                    mul_start = 1'b1;
                    state_d   = MUL;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    rd_d        = alu_rd;
                    addr_d      = alu_addr;
                    pc_next_d   = alu_pc;
                    br_taken_d  = alu_br;
                    ovf_d       = alu_ovf;
                    illegal_d   = alu_ill;
                end
            end
            MUL: if (mul_done) state_d = DONE;
            DONE: begin
                out_valid_d = 1'b1;
                rd_d        = mul_product;
                addr_d      = '0;
                pc_next_d   = '0;
                br_taken_d  = 1'b0;
                ovf_d       = 1'b0;
                illegal_d   = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            addr_q      <= '0;
            pc_next_q   <= '0;
            br_taken_q  <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            pc_next_q   <= pc_next_d;
            br_taken_q  <= br_taken_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
        end
    end

    ex_mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
        .clk     (clk),
        .abort   (rst),
        .start   (mul_start),
        .mcand   (rs),
        .mplier  (opnd2),
        .done    (mul_done),
        .product (mul_product)
    );

    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign addr      = addr_q;
    assign pc_next   = pc_next_q;
    assign br_taken  = br_taken_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ex_unit_pipe.sv
// Bench for ex_unit_pipe: directed vector table, handshake/reset sequences,
// and random ops checked against an arithmetic reference model.
module tb_ex_unit_pipe;
    import ex_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_valid4 = 1'b0;
    logic          out_ready = 1'b1, out_ready4 = 1'b1;
    logic [5:0]    op = '0;
    logic [W-1:0]  rs = '0, rt = '0, imm = '0, pc4 = '0, br_off = '0;
    logic          in_ready, out_valid, br_taken, ovf, illegal;
    logic [W-1:0]  rd, addr, pc_next;
    logic          in_ready4, out_valid4, br_taken4, ovf4, illegal4;
    logic [W-1:0]  rd4, addr4, pc_next4;

    always #5 clk = ~clk;

    ex_unit_pipe #(.WIDTH(W), .MUL_STEP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rs(rs), .rt(rt), .imm(imm), .pc4(pc4), .br_off(br_off),
        .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .addr(addr),
        .pc_next(pc_next), .br_taken(br_taken), .ovf(ovf), .illegal(illegal)
    );

    ex_unit_pipe #(.WIDTH(W), .MUL_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op(op),
        .rs(rs), .rt(rt), .imm(imm), .pc4(pc4), .br_off(br_off),
        .out_valid(out_valid4), .out_ready(out_ready4), .rd(rd4), .addr(addr4),
        .pc_next(pc_next4), .br_taken(br_taken4), .ovf(ovf4), .illegal(illegal4)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] pc;
        logic        br;
        logic        ovf;
        logic        ill;
    } res_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] rs, rt, imm, pc4, off;
        res_t        exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on 64-bit values.
    function automatic res_t model(input logic [5:0] o, input logic [31:0] a, b, im, p4, off);
        res_t        r;
        logic [31:0] s;
        longint      sa, sb, wide;
        logic [63:0] prod;
        r  = '0;
        s  = (o == 6'h01 || o == 6'h03 || o == 6'h05 || o == 6'h07 || o == 6'h09 ||
              o == 6'h0B || o == 6'h0C || o == 6'h0D) ? im : b;
        sa = longint'($signed(a));
        sb = longint'($signed(s));
        case (o)
            6'h00, 6'h01: begin
                wide  = sa + sb;
                r.rd  = a + s;
                r.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            6'h02, 6'h03: begin
                wide  = sa - sb;
                r.rd  = a - s;
                r.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            6'h04, 6'h05: begin
                prod = {32'b0, a} * {32'b0, s};
                r.rd = prod[31:0];
            end
            6'h06, 6'h07: r.rd = a | s;
            6'h08, 6'h09: r.rd = a & s;
            6'h0A, 6'h0B: r.rd = a ^ s;
            6'h0C, 6'h0D: r.addr = a + im;
            6'h0E: begin r.br = (a == 0);  r.pc = r.br ? p4 + off : p4; end
            6'h0F: begin r.br = (a == b);  r.pc = r.br ? p4 + off : p4; end
            6'h10: begin r.br = 1'b1;      r.pc = a; end
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    function automatic vec_t mk(input logic [5:0] o, input logic [31:0] a, b, im, p4, off,
                                input logic [31:0] erd, eaddr, epc, input logic ebr, eovf, eill);
        vec_t v;
        v.op = o; v.rs = a; v.rt = b; v.imm = im; v.pc4 = p4; v.off = off;
        v.exp.rd = erd; v.exp.addr = eaddr; v.exp.pc = epc;
        v.exp.br = ebr; v.exp.ovf = eovf; v.exp.ill = eill;
        return v;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op on the MUL_STEP=1 unit and check its result.
    task automatic issue(input vec_t v, input string tag);
        int   lat;
        logic stayed_low;
        op = v.op; rs = v.rs; rt = v.rt; imm = v.imm; pc4 = v.pc4; br_off = v.off;
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs = $urandom; rt = $urandom; imm = $urandom;
        if (v.op == 6'h04 || v.op == 6'h05) begin
            lat = 0;
            stayed_low = 1'b1;
            while (!out_valid && lat < 200) begin
                if (in_ready) stayed_low = 1'b0;
                @(posedge clk); #1;
                lat++;
            end
            chk({tag, "_mul_latency"}, 32'(lat), 32'd33);
            chk({tag, "_busy_in_ready_low"}, 32'(stayed_low), 32'd1);
        end
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_rd"},        rd,             v.exp.rd);
        chk({tag, "_addr"},      addr,           v.exp.addr);
        chk({tag, "_pc_next"},   pc_next,        v.exp.pc);
        chk({tag, "_br_taken"},  32'(br_taken),  32'(v.exp.br));
        chk({tag, "_ovf"},       32'(ovf),       32'(v.exp.ovf));
        chk({tag, "_illegal"},   32'(illegal),   32'(v.exp.ill));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[12];
        vec_t v;
        int   lat, seen, k;

        tbl[0]  = mk(6'h00, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 1, 0);
        tbl[1]  = mk(6'h03, 32'h5, 0, 32'h7, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
        tbl[2]  = mk(6'h09, 32'hF0F0, 0, 32'hFF, 0, 0, 32'hF0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(6'h04, 32'hFFFF_FFFD, 32'h7, 0, 0, 0, 32'hFFFF_FFEB, 0, 0, 0, 0, 0);
        tbl[4]  = mk(6'h0F, 32'h9, 32'h9, 0, 32'h100, 32'h20, 0, 0, 32'h120, 1, 0, 0);
        tbl[5]  = mk(6'h0E, 32'h1, 0, 0, 32'h104, 32'h20, 0, 0, 32'h104, 0, 0, 0);
        tbl[6]  = mk(6'h10, 32'h400, 0, 0, 32'h108, 32'h20, 0, 0, 32'h400, 1, 0, 0);
        tbl[7]  = mk(6'h2A, 32'h5, 32'h6, 32'h7, 32'h10, 32'h20, 0, 0, 0, 0, 0, 1);
        tbl[8]  = mk(6'h02, 32'h8000_0000, 32'h1, 0, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 1, 0);
        tbl[9]  = mk(6'h05, 32'h6, 0, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFF4, 0, 0, 0, 0, 0);
        tbl[10] = mk(6'h0D, 32'h2000, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'h1FFC, 0, 0, 0, 0);
        tbl[11] = mk(6'h0A, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 0, 0, 32'h5A5A_A5A5, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_rd",        rd,             0);
        chk("rst_addr",      addr,           0);
        chk("rst_pc_next",   pc_next,        0);
        chk("rst_br_ovf_ill", {29'b0, br_taken, ovf, illegal}, 0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_valid4", 32'(out_valid4), 0);
        rst = 1'b0;

        foreach (tbl[i]) issue(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: LDW result must hold while out_ready is low.
        issue(mk(6'h0C, 32'h1000, 0, 32'h10, 0, 0, 0, 32'h1010, 0, 0, 0, 0), "ldw");
        op = 6'h00; rs = 32'h2; rt = 32'h3; in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("stall%0d_out_valid", c), 32'(out_valid), 1);
            chk($sformatf("stall%0d_addr", c),      addr,           32'h1010);
            chk($sformatf("stall%0d_in_ready", c),  32'(in_ready),  0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_rd",        rd,             32'h5);
        chk("release_addr",      addr,           0);
        chk("release_out_valid", 32'(out_valid), 1);

        // Reset 10 cycles into a multiply discards it.
        op = 6'h04; rs = 32'h3; rt = 32'h4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midmul_rst_out_valid", 32'(out_valid), 0);
        chk("midmul_rst_in_ready",  32'(in_ready),  1);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midmul_no_output", 32'(seen), 0);
        issue(mk(6'h00, 32'h2, 32'h3, 0, 0, 0, 32'h5, 0, 0, 0, 0, 0), "post_rst_add");

        // Four bits per cycle: latency MUL_ITERS+1 = 9.
        op = 6'h04; rs = 32'hFFFF_FFFD; rt = 32'h7; in_valid4 = 1'b1;
        #1;
        chk("mul4_in_ready", 32'(in_ready4), 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        rs = $urandom; rt = $urandom;
        lat = 0;
        while (!out_valid4 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("mul4_latency", 32'(lat), 32'd9);
        chk("mul4_rd",      rd4,      32'hFFFF_FFEB);
        chk("mul4_addr_br", addr4 | pc_next4 | {29'b0, br_taken4, ovf4, illegal4}, 0);

        // Random ops against the model, with occasional stalls and gaps.
        for (int n = 0; n < 300; n++) begin
            v.op  = 6'($urandom_range(0, 20));
            v.rs  = pick();
            v.rt  = $urandom_range(0, 3) == 0 ? v.rs : pick();
            v.imm = pick();
            v.pc4 = $urandom & 32'hFFFF_FFFC;
            v.off = $urandom & 32'h0000_FFFC;
            v.exp = model(v.op, v.rs, v.rt, v.imm, v.pc4, v.off);
            issue(v, $sformatf("rnd%0d_op%0h", n, v.op));
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                k = $urandom_range(1, 3);
                for (int c = 0; c < k; c++) begin
                    @(posedge clk); #1;
                    chk($sformatf("rnd%0d_hold_rd", n),       rd,             v.exp.rd);
                    chk($sformatf("rnd%0d_hold_pc", n),       pc_next,        v.exp.pc);
                    chk($sformatf("rnd%0d_hold_in_ready", n), 32'(in_ready),  0);
                end
                out_ready = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk($sformatf("rnd%0d_drain", n), 32'(out_valid), 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
